// File: rtl/binary_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : binary_to_bcd_seq
// Brief   : Sequential double-dabble binary-to-BCD converter, one bit per
//           clock. Optional macro LEADING_ZERO_BLANK_EN adds a registered
//           leading-zero mask output (blank).
// Revision: 1.0 - initial release
// ============================================================================
module binary_to_bcd_seq #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
`ifdef LEADING_ZERO_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int c_work_w = 4 * DIGITS;
  localparam int c_cnt_w  = $clog2(BIN_W + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(BIN_W);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BIN_W-1:0]      r_bin;
  logic [c_work_w-1:0]   r_work;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_acc;
  logic [c_work_w-1:0]   r_bcd;
  logic                  r_ovf;
  logic                  r_done;
  logic [c_work_w-1:0]   w_adj;
  logic [c_work_w-1:0]   w_work_nxt;
  logic                  w_carry;
  logic                  w_last;

  // Add-3 correction on every digit before the shift
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    assign w_adj[4*k+3:4*k] = (r_work[4*k+3:4*k] > 4'd4) ? (r_work[4*k+3:4*k] + 4'd3)
                                                          : r_work[4*k+3:4*k];
  end

  assign w_work_nxt = {w_adj[c_work_w-2:0], r_bin[BIN_W-1]};
  assign w_carry    = w_adj[c_work_w-1];
  assign w_last     = (r_state == S_SHIFT) && (r_cnt == c_cnt_one);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= '0;
      r_work <= '0;
      r_cnt  <= '0;
      r_acc  <= 1'b0;
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_bin  <= binary;
          r_work <= '0;
          r_acc  <= 1'b0;
          r_cnt  <= c_cnt_load;
        end
      end else begin
        r_work <= w_work_nxt;
        r_bin  <= {r_bin[BIN_W-2:0], 1'b0};
        r_cnt  <= r_cnt - c_cnt_one;
        r_acc  <= r_acc | w_carry;
        if (w_last) begin
          r_bcd  <= w_work_nxt;
          r_ovf  <= r_acc | w_carry;
          r_done <= 1'b1;
        end
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank_nxt;

  // Digit 0 is never blanked so a zero result still shows one digit
  assign w_blank_nxt[0] = 1'b0;
  for (genvar k = 1; k < DIGITS; k++) begin : g_blank
    assign w_blank_nxt[k] = (w_work_nxt[c_work_w-1:4*k] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blank <= '1;
    end else if (w_last) begin
      r_blank <= w_blank_nxt;
    end
  end

  assign blank = r_blank;
`endif

  assign busy     = (r_state == S_SHIFT);
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_binary_to_bcd_seq.sv
`default_nettype none
// Self-checking bench for binary_to_bcd_seq: default 10-bit/4-digit instance
// plus a 2-digit instance for the overflow cases.
module tb_binary_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start2;
  logic [9:0]  bin1, bin2;
  logic        busy1, busy2, done1, done2, ovf1, ovf2;
  logic [15:0] bcd1;
  logic [7:0]  bcd2;
`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0]  blank1;
  logic [1:0]  blank2;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  binary_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .binary(bin1),
    .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1)
`ifdef LEADING_ZERO_BLANK_EN
    , .blank(blank1)
`endif
  );

  binary_to_bcd_seq #(.BIN_W(10), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .binary(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
`ifdef LEADING_ZERO_BLANK_EN
    , .blank(blank2)
`endif
  );

  // Starts one conversion on the chosen instance and waits (bounded) for done.
  // Returns on the falling edge where done is observed; lat = -1 on timeout.
  task automatic run_conv(input int which, input logic [9:0] val,
                          output int lat, output int busy_cyc);
    lat = -1;
    busy_cyc = 0;
    @(negedge clk);
    if (which == 1) begin start1 = 1'b1; bin1 = val; end
    else            begin start2 = 1'b1; bin2 = val; end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin start1 = 1'b0; start2 = 1'b0; end
      if ((which == 1) ? busy1 : busy2) busy_cyc++;
      if ((which == 1) ? done1 : done2) begin
        lat = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; bin1 = '0; bin2 = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy1); end
    n_vec++; if (done1 !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done1); end
    n_vec++; if (bcd1 !== 16'h0000) begin n_err++; $display("FAIL rst_bcd: got %h want 0000", bcd1); end
    n_vec++; if (ovf1 !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", ovf1); end
    n_vec++; if (bcd2 !== 8'h00) begin n_err++; $display("FAIL rst_bcd2: got %h want 00", bcd2); end
`ifdef LEADING_ZERO_BLANK_EN
    n_vec++; if (blank1 !== 4'b1111) begin n_err++; $display("FAIL rst_blank: got %b want 1111", blank1); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_zero();
    int lat, bc;
    run_conv(1, 10'd0, lat, bc);
    n_vec++; if (lat !== 11) begin n_err++; $display("FAIL zero_latency: got %0d want 11", lat); end
    n_vec++; if (bc !== 10) begin n_err++; $display("FAIL zero_busy_cycles: got %0d want 10", bc); end
    n_vec++; if (bcd1 !== 16'h0000) begin n_err++; $display("FAIL zero_bcd: got %h want 0000", bcd1); end
    n_vec++; if (ovf1 !== 1'b0) begin n_err++; $display("FAIL zero_ovf: got %b want 0", ovf1); end
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL zero_busy_done: got %b want 0", busy1); end
`ifdef LEADING_ZERO_BLANK_EN
    n_vec++; if (blank1 !== 4'b1110) begin n_err++; $display("FAIL zero_blank: got %b want 1110", blank1); end
`endif
    @(negedge clk);
    n_vec++; if (done1 !== 1'b0) begin n_err++; $display("FAIL zero_done_pulse: got %b want 0", done1); end
  endtask

  task automatic test_max();
    int lat, bc;
    run_conv(1, 10'd1023, lat, bc);
    n_vec++; if (bcd1 !== 16'h1023) begin n_err++; $display("FAIL max_bcd: got %h want 1023", bcd1); end
    n_vec++; if (ovf1 !== 1'b0) begin n_err++; $display("FAIL max_ovf: got %b want 0", ovf1); end
    run_conv(1, 10'd999, lat, bc);
    n_vec++; if (bcd1 !== 16'h0999) begin n_err++; $display("FAIL b999_bcd: got %h want 0999", bcd1); end
    n_vec++; if (lat !== 11) begin n_err++; $display("FAIL b999_latency: got %0d want 11", lat); end
    run_conv(1, 10'd586, lat, bc);
    n_vec++; if (bcd1 !== 16'h0586) begin n_err++; $display("FAIL b586_bcd: got %h want 0586", bcd1); end
  endtask

  task automatic test_overflow();
    int lat, bc;
    run_conv(2, 10'd123, lat, bc);
    n_vec++; if (bcd2 !== 8'h23) begin n_err++; $display("FAIL ovf123_bcd: got %h want 23", bcd2); end
    n_vec++; if (ovf2 !== 1'b1) begin n_err++; $display("FAIL ovf123_ovf: got %b want 1", ovf2); end
    run_conv(2, 10'd99, lat, bc);
    n_vec++; if (bcd2 !== 8'h99) begin n_err++; $display("FAIL ovf99_bcd: got %h want 99", bcd2); end
    n_vec++; if (ovf2 !== 1'b0) begin n_err++; $display("FAIL ovf99_ovf: got %b want 0", ovf2); end
    run_conv(2, 10'd100, lat, bc);
    n_vec++; if (bcd2 !== 8'h00) begin n_err++; $display("FAIL ovf100_bcd: got %h want 00", bcd2); end
    n_vec++; if (ovf2 !== 1'b1) begin n_err++; $display("FAIL ovf100_ovf: got %b want 1", ovf2); end
`ifdef LEADING_ZERO_BLANK_EN
    n_vec++; if (blank2 !== 2'b10) begin n_err++; $display("FAIL ovf100_blank: got %b want 10", blank2); end
`endif
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    int lat = -1;
    @(negedge clk);
    start1 = 1'b1; bin1 = 10'd500;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start1 = 1'b0;
      if (cyc == 3) begin start1 = 1'b1; bin1 = 10'd7; end
      if (cyc == 4) begin start1 = 1'b0; bin1 = 10'h3FF; end
      if (done1) begin
        dones++;
        if (lat < 0) lat = cyc;
      end
    end
    n_vec++; if (dones !== 1) begin n_err++; $display("FAIL ignore_dones: got %0d want 1", dones); end
    n_vec++; if (lat !== 11) begin n_err++; $display("FAIL ignore_latency: got %0d want 11", lat); end
    n_vec++; if (bcd1 !== 16'h0500) begin n_err++; $display("FAIL ignore_bcd: got %h want 0500", bcd1); end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    int lat, bc;
    @(negedge clk);
    start1 = 1'b1; bin1 = 10'd321;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start1 = 1'b0;
    end
    rst = 1'b1;
    #1;
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy1); end
    n_vec++; if (bcd1 !== 16'h0000) begin n_err++; $display("FAIL abort_bcd: got %h want 0000", bcd1); end
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (done1) dones++;
    end
    n_vec++; if (dones !== 0) begin n_err++; $display("FAIL abort_done: got %0d want 0", dones); end
    n_vec++; if (bcd1 !== 16'h0000) begin n_err++; $display("FAIL abort_bcd_after: got %h want 0000", bcd1); end
    run_conv(1, 10'd321, lat, bc);
    n_vec++; if (lat !== 11) begin n_err++; $display("FAIL fresh_latency: got %0d want 11", lat); end
    n_vec++; if (bcd1 !== 16'h0321) begin n_err++; $display("FAIL fresh_bcd: got %h want 0321", bcd1); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    int lat2 = -1;
    run_conv(1, 10'd7, lat, bc);
    n_vec++; if (bcd1 !== 16'h0007) begin n_err++; $display("FAIL b2b_first_bcd: got %h want 0007", bcd1); end
`ifdef LEADING_ZERO_BLANK_EN
    n_vec++; if (blank1 !== 4'b1110) begin n_err++; $display("FAIL blank7: got %b want 1110", blank1); end
`endif
    start1 = 1'b1; bin1 = 10'd1000;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start1 = 1'b0;
        n_vec++; if (done1 !== 1'b0) begin n_err++; $display("FAIL b2b_done_width: got %b want 0", done1); end
        n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got busy %b want 1", busy1); end
      end
      if (done1) begin lat2 = cyc; break; end
    end
    n_vec++; if (lat2 !== 11) begin n_err++; $display("FAIL b2b_latency: got %0d want 11", lat2); end
    n_vec++; if (bcd1 !== 16'h1000) begin n_err++; $display("FAIL b2b_bcd: got %h want 1000", bcd1); end
`ifdef LEADING_ZERO_BLANK_EN
    n_vec++; if (blank1 !== 4'b0000) begin n_err++; $display("FAIL blank1000: got %b want 0000", blank1); end
`endif
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_overflow();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/binary_to_bcd_seq.md
BINARY_TO_BCD_SEQ -- requirements
Module: binary_to_bcd_seq

Interface
REQ-001 Parameter BIN_W, default 10: binary input width, minimum 4.
REQ-002 Parameter DIGITS, default 4: number of BCD output digits, minimum 1.
REQ-003 clk  input  1: single clock, all state updates on rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 start  input  1: conversion request, sampled on rising edge of clk.
REQ-006 binary  input  BIN_W: unsigned value, captured on the accepted start edge only.
REQ-007 busy  output  1: high while a conversion is in progress.
REQ-008 done  output  1: one-cycle pulse when a result is valid.
REQ-009 bcd  output  4*DIGITS: registered result, digit 0 in bits [3:0], digit k in bits [4k+3:4k].
REQ-010 overflow  output  1: registered, high when the last converted value was 10^DIGITS or greater.
REQ-011 blank  output  DIGITS: leading-zero mask, present only under LEADING_ZERO_BLANK_EN (REQ-029).

Function
REQ-012 FSM states: IDLE, SHIFT; busy SHALL be high exactly when the state is SHIFT.
REQ-013 IDLE, start=1: capture binary into the shift register, clear the BCD work register, clear the overflow accumulator, load the bit counter with BIN_W, go to SHIFT.
REQ-014 IDLE, start=0: hold state; bcd, overflow and blank hold their last values.
REQ-015 SHIFT, each cycle, step 1: add 3 to every work digit greater than 4.
REQ-016 SHIFT, each cycle, step 2: shift the {work, binary} register left by 1 and decrement the counter.
REQ-017 The bit shifted out of the top work digit SHALL be ORed into the overflow accumulator.
REQ-018 SHIFT with counter reaching 0 after that cycle's shift:
  - load bcd from the final work register;
  - load overflow from the accumulator, including the final shifted-out bit;
  - assert done for that one cycle;
  - return to IDLE.
REQ-019 Latency: for a start accepted at edge N, done is high and bcd is valid in the cycle following edge N+BIN_W; throughput is one conversion per BIN_W+1 cycles.
REQ-020 start while busy=1 SHALL be ignored; it does not restart, queue or alter the running conversion, and changes on binary while busy=1 SHALL have no effect.
REQ-021 start high in the done cycle SHALL be accepted (state is IDLE), giving back-to-back conversions.
REQ-022 On overflow, bcd SHALL equal the value modulo 10^DIGITS.
REQ-023 bcd digits SHALL always be in the range 0..9.
REQ-024 done SHALL never be asserted for two consecutive cycles.

Reset
REQ-025 While rst=1, regardless of clk:
  - state = IDLE;
  - busy = 0, done = 0;
  - bcd = 0, overflow = 0;
  - blank = all ones when present;
  - counter and work registers = 0.
REQ-026 rst asserted mid-conversion SHALL abort the conversion, with no done pulse and no bcd update, either during rst or after its release.
REQ-027 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN controls the blank output.
REQ-029 With LEADING_ZERO_BLANK_EN defined:
  - blank[k] = 1 when digit k and all higher digits are 0, for k >= 1;
  - blank[0] = 0, except all ones after reset;
  - blank updates in the same cycle as bcd.
REQ-030 Without LEADING_ZERO_BLANK_EN: the blank port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Defaults, binary=0, start pulse -> busy high 10 cycles; done pulse; bcd=16'h0000; overflow=0.
REQ-032 Defaults, binary=1023 -> bcd=16'h1023, overflow=0; binary=999 -> bcd=16'h0999; done exactly 11 cycles after the start edge.
REQ-033 DIGITS=2, BIN_W=10, binary=123 -> bcd=8'h23, overflow=1; then binary=99 -> bcd=8'h99, overflow=0.
REQ-034 Start binary=500, then start with binary=7 three cycles later -> second start ignored; bcd=16'h0500; single done pulse.
REQ-035 Start binary=321, rst pulse at cycle 4 -> busy=0 and bcd=0 immediately; no done pulse; a fresh start converts correctly.
REQ-036 Macro defined, binary=7 -> blank=4'b1110; binary=1000 -> blank=4'b0000; back-to-back start in the done cycle -> second result after 11 further cycles.
